// File: rtl/chirp_phase_if.sv
// ---------------------------------------------------------------------------
// chirp_phase_if
//   Control / configuration / sample bus of the chirp phase generator.
//   master : drives start/stop and cfg_*, receives strobe, phase words and status
//   slave  : the generator side (inverse directions)
//   Signals:
//     start, stop      run control pulses
//     cfg_mode/div     sweep mode, strobe period minus one
//     cfg_freq0/1      start / end frequency (signed)
//     cfg_rate         per-strobe frequency increment (signed)
//     cfg_offset       per-channel phase offset, ch k at [k*OUT_W +: OUT_W]
//     strobe           one-cycle sample strobe (phase_tvalid mirrors it)
//     phase_tdata      per-channel phase words
//     freq_out         current frequency register
//     busy, done       running flag, end-of-sweep pulse
// ---------------------------------------------------------------------------
interface chirp_phase_if #(
    parameter int PHASE_W = 48,
    parameter int OUT_W   = 16,
    parameter int NCH     = 2,
    parameter int DIV_W   = 3
);
    logic                       start;
    logic                       stop;
    logic [1:0]                 cfg_mode;
    logic [DIV_W-1:0]           cfg_div;
    logic signed [PHASE_W-1:0]  cfg_freq0;
    logic signed [PHASE_W-1:0]  cfg_freq1;
    logic signed [PHASE_W-1:0]  cfg_rate;
    logic [NCH*OUT_W-1:0]       cfg_offset;
    logic                       strobe;
    logic                       phase_tvalid;
    logic [NCH*OUT_W-1:0]       phase_tdata;
    logic signed [PHASE_W-1:0]  freq_out;
    logic                       busy;
    logic                       done;

    modport master (
        output start, stop, cfg_mode, cfg_div, cfg_freq0, cfg_freq1, cfg_rate, cfg_offset,
        input  strobe, phase_tvalid, phase_tdata, freq_out, busy, done
    );

    modport slave (
        input  start, stop, cfg_mode, cfg_div, cfg_freq0, cfg_freq1, cfg_rate, cfg_offset,
        output strobe, phase_tvalid, phase_tdata, freq_out, busy, done
    );
endinterface

// File: rtl/chirp_phase_gen.sv
// ---------------------------------------------------------------------------
// chirp_phase_gen
//   Multi-channel phase-word generator: a strobe every DIV+1 clocks, and per
//   strobe an accumulated phase whose top OUT_W bits (plus a per-channel
//   offset) are presented as phase words. Frequency evolves per mode:
//   0 tone, 1 wrapping linear chirp, 2 one-shot sweep to freq1, 3 bounce
//   sweep between freq0 and freq1.
//   Ports:
//     clk    system clock
//     rst_n  synchronous reset, active low
//     io     chirp_phase_if slave (control, config, samples, status)
// ---------------------------------------------------------------------------
module chirp_phase_gen #(
    parameter int PHASE_W = 48,
    parameter int OUT_W   = 16,
    parameter int NCH     = 2,
    parameter int DIV_W   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    chirp_phase_if.slave  io
);
    localparam int W = PHASE_W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                 state_q;
    logic [DIV_W-1:0]       cnt_q;
    logic [DIV_W-1:0]       div_q;
    logic [1:0]             mode_q;
    logic signed [W-1:0]    phase_q;
    logic signed [W-1:0]    freq_q;
    logic signed [W-1:0]    rate_q;
    logic signed [W-1:0]    freq0_q;
    logic signed [W-1:0]    freq1_q;
    logic [NCH*OUT_W-1:0]   offset_q;
    logic [NCH*OUT_W-1:0]   tdata_q;
    logic                   strobe_q;
    logic                   done_q;
    logic                   dir_q;      // bounce direction: 0 toward freq1, 1 back to freq0

    logic signed [W-1:0]    tgt_d;
    logic signed [W:0]      f_ext_d;
    logic signed [W:0]      tgt_ext_d;
    logic                   hit_d;
    logic [NCH*OUT_W-1:0]   tdata_d;

    // Sweep end test on one extra bit, so freq+rate overflow cannot flip the result.
    function automatic logic reached(input logic signed [W:0] f,
                                     input logic signed [W:0] tgt,
                                     input logic              down);
        return down ? (f <= tgt) : (f >= tgt);
    endfunction

    always_comb begin
        tgt_d     = (mode_q == 2'd3 && dir_q) ? freq0_q : freq1_q;
        f_ext_d   = $signed({freq_q[W-1], freq_q}) + $signed({rate_q[W-1], rate_q});
        tgt_ext_d = $signed({tgt_d[W-1], tgt_d});
        hit_d     = reached(f_ext_d, tgt_ext_d, rate_q[W-1]);
        tdata_d   = '0;
        for (int k = 0; k < NCH; k++) begin
            tdata_d[k*OUT_W +: OUT_W] = phase_q[W-1 -: OUT_W] + offset_q[k*OUT_W +: OUT_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            phase_q  <= '0;
            freq_q   <= '0;
            rate_q   <= '0;
            tdata_q  <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            dir_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (io.stop) begin
                state_q  <= S_IDLE;
                strobe_q <= 1'b0;
                freq_q   <= '0;
            end else if (io.start && state_q != S_RUN) begin
                state_q  <= S_RUN;
                mode_q   <= io.cfg_mode;
                div_q    <= io.cfg_div;
                freq0_q  <= io.cfg_freq0;
                freq1_q  <= io.cfg_freq1;
                offset_q <= io.cfg_offset;
                rate_q   <= io.cfg_rate;
                freq_q   <= io.cfg_freq0;
                cnt_q    <= io.cfg_div;
                phase_q  <= '0;
                strobe_q <= 1'b0;
                dir_q    <= 1'b0;
            end else if (state_q != S_IDLE) begin
                if (cnt_q == '0) begin
                    cnt_q    <= div_q;
                    strobe_q <= 1'b1;
                    tdata_q  <= tdata_d;     // sample the phase before this update
                    phase_q  <= phase_q + freq_q;
                    // In DONE the frequency is frozen at freq1.
                    if (state_q == S_RUN) begin
                        unique case (mode_q)
                            2'd0: ;
                            2'd1: freq_q <= f_ext_d[W-1:0];
                            2'd2: begin
                                if (hit_d) begin
                                    freq_q  <= freq1_q;
                                    state_q <= S_DONE;
                                    done_q  <= 1'b1;
                                end else begin
                                    freq_q <= f_ext_d[W-1:0];
                                end
                            end
                            2'd3: begin
                                if (hit_d) begin
                                    freq_q <= tgt_d;
                                    rate_q <= -rate_q;
                                    dir_q  <= ~dir_q;
                                end else begin
                                    freq_q <= f_ext_d[W-1:0];
                                end
                            end
                        endcase
                    end
                end else begin
                    cnt_q    <= cnt_q - 1'b1;
                    strobe_q <= 1'b0;
                end
            end
        end
    end

    assign io.strobe       = strobe_q;
    assign io.phase_tvalid = strobe_q;
    assign io.phase_tdata  = tdata_q;
    assign io.freq_out     = freq_q;
    assign io.busy         = (state_q == S_RUN);
    assign io.done         = done_q;
endmodule

// File: tb/tb_chirp_phase_gen.sv
// ---------------------------------------------------------------------------
// tb_chirp_phase_gen
//   Directed bench for chirp_phase_gen: reset/idle, tone, wrapping chirp
//   against a reference accumulator, one-shot sweep, bounce sweep with div=0,
//   start/stop priority, stop mid-run and reset mid-run.
// ---------------------------------------------------------------------------
module tb_chirp_phase_gen;
    localparam int PW = 48;
    localparam int OW = 16;
    localparam int NC = 2;
    localparam int DW = 3;

    localparam logic [PW-1:0] F40 = 48'h0100_0000_0000;   // 2^40
    localparam logic [PW-1:0] F41 = 48'h0200_0000_0000;   // 2^41
    localparam logic [PW-1:0] F44 = 48'h1000_0000_0000;   // 2^44
    localparam logic [PW-1:0] F35 = 48'h0380_0000_0000;   // 3.5 * 2^40

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    chirp_phase_if #(.PHASE_W(PW), .OUT_W(OW), .NCH(NC), .DIV_W(DW)) bus ();

    chirp_phase_gen #(.PHASE_W(PW), .OUT_W(OW), .NCH(NC), .DIV_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to the next strobe (sampled on negedge); n = negedges waited.
    task automatic wait_strobe(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.strobe && n < 40);
        if (!bus.strobe) chk("strobe_timeout", 64'd0, 64'd1);
    endtask

    task automatic start_run(input logic [1:0] mode, input logic [DW-1:0] div,
                             input logic [PW-1:0] f0, input logic [PW-1:0] f1,
                             input logic [PW-1:0] rate, input logic [NC*OW-1:0] off);
        bus.cfg_mode   = mode;
        bus.cfg_div    = div;
        bus.cfg_freq0  = f0;
        bus.cfg_freq1  = f1;
        bus.cfg_rate   = rate;
        bus.cfg_offset = off;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start      = 1'b0;
        // Config must only matter on the start edge.
        bus.cfg_mode   = ~mode;
        bus.cfg_div    = ~div;
        bus.cfg_freq0  = 48'h5a5a_5a5a_5a5a;
        bus.cfg_freq1  = 48'ha5a5_a5a5_a5a5;
        bus.cfg_rate   = 48'h0123_4567_89ab;
        bus.cfg_offset = 32'hdead_beef;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
    endtask

    task automatic count_strobes(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.strobe || bus.phase_tvalid) cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        logic [15:0] c0;
        logic [PW-1:0] ph;
        logic [PW-1:0] fr;
        logic [PW-1:0] rate3;
        logic [PW-1:0] exp4 [4];
        int exp5 [6];

        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.cfg_mode   = '0;
        bus.cfg_div    = '0;
        bus.cfg_freq0  = '0;
        bus.cfg_freq1  = '0;
        bus.cfg_rate   = '0;
        bus.cfg_offset = '0;

        // Reset and idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_strobe", 64'(bus.strobe), 64'd0);
        chk("rst_tvalid", 64'(bus.phase_tvalid), 64'd0);
        chk("rst_tdata", 64'(bus.phase_tdata), 64'd0);
        chk("rst_freq", 64'($unsigned(bus.freq_out)), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.strobe || bus.busy || bus.done || bus.freq_out != 0) cnt++;
        end
        chk("idle_quiet", 64'(cnt), 64'd0);

        // Tone, div=6, 2^44 per strobe -> +0x1000 per sample on ch0
        start_run(2'd0, 3'd6, F44, '0, '0, {16'h4000, 16'h0000});
        chk("t2_busy", 64'(bus.busy), 64'd1);
        chk("t2_freq0", 64'($unsigned(bus.freq_out)), 64'(F44));
        for (int i = 0; i < 17; i++) begin
            wait_strobe(n);
            chk("t2_period", 64'(n), 64'd7);
            c0 = 16'(i) << 12;
            chk("t2_tdata", 64'(bus.phase_tdata), 64'({c0 + 16'h4000, c0}));
        end
        chk("t2_freq_const", 64'($unsigned(bus.freq_out)), 64'(F44));
        pulse_stop();

        // Wrapping chirp against a reference accumulator
        rate3 = 48'h0000_07ff_ffff;
        start_run(2'd1, 3'd6, 48'hff00_0000_0000, '0, rate3, '0);
        ph = '0;
        fr = 48'hff00_0000_0000;
        for (int i = 0; i < 1000; i++) begin
            wait_strobe(n);
            chk("t3_period", 64'(n), 64'd7);
            chk("t3_tdata", 64'(bus.phase_tdata), 64'({ph[47:32], ph[47:32]}));
            ph = ph + fr;
            fr = fr + rate3;
            chk("t3_freq", 64'($unsigned(bus.freq_out)), 64'(fr));
        end
        pulse_stop();

        // One-shot sweep 0 -> 3.5*2^40 in 2^40 steps, div=1
        start_run(2'd2, 3'd1, '0, F35, F40, '0);
        chk("t4_freq0", 64'($unsigned(bus.freq_out)), 64'd0);
        exp4[0] = F40;
        exp4[1] = 48'h0200_0000_0000;
        exp4[2] = 48'h0300_0000_0000;
        exp4[3] = F35;
        for (int i = 0; i < 4; i++) begin
            wait_strobe(n);
            chk("t4_freq", 64'($unsigned(bus.freq_out)), 64'(exp4[i]));
            chk("t4_done", 64'(bus.done), (i == 3) ? 64'd1 : 64'd0);
            chk("t4_busy", 64'(bus.busy), (i == 3) ? 64'd0 : 64'd1);
        end
        chk("t4_tdata4", 64'(bus.phase_tdata), 64'h0300_0300);
        @(negedge clk);
        chk("t4_done_pulse", 64'(bus.done), 64'd0);
        wait_strobe(n);
        chk("t4_tdata5", 64'(bus.phase_tdata), 64'h0600_0600);
        chk("t4_freq_hold", 64'($unsigned(bus.freq_out)), 64'(F35));
        wait_strobe(n);
        chk("t4_tdata6", 64'(bus.phase_tdata), 64'h0980_0980);
        chk("t4_busy_done", 64'(bus.busy), 64'd0);

        // Bounce sweep 0 <-> 2^41, restarted from DONE, div=0
        start_run(2'd3, 3'd0, '0, F41, F40, '0);
        chk("t5_busy", 64'(bus.busy), 64'd1);
        chk("t5_freq0", 64'($unsigned(bus.freq_out)), 64'd0);
        exp5 = '{1, 2, 1, 0, 1, 2};
        for (int i = 0; i < 6; i++) begin
            wait_strobe(n);
            chk("t5_period", 64'(n), 64'd1);
            chk("t5_freq", 64'($unsigned(bus.freq_out)), 64'(exp5[i]) << 40);
        end

        // stop wins over start; stop mid-run; reset mid-run
        pulse_stop();
        chk("t6_stop_busy", 64'(bus.busy), 64'd0);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk("t6_startstop_busy", 64'(bus.busy), 64'd0);
        count_strobes(10, cnt);
        chk("t6_startstop_quiet", 64'(cnt), 64'd0);

        start_run(2'd0, 3'd6, F44, '0, '0, {16'h4000, 16'h0000});
        wait_strobe(n);
        repeat (3) @(negedge clk);
        pulse_stop();
        chk("t6_stop_freq", 64'($unsigned(bus.freq_out)), 64'd0);
        chk("t6_stop_busy2", 64'(bus.busy), 64'd0);
        count_strobes(20, cnt);
        chk("t6_stop_quiet", 64'(cnt), 64'd0);
        chk("t6_tdata_held", 64'(bus.phase_tdata), 64'h4000_0000);

        start_run(2'd0, 3'd6, F44, '0, '0, '0);
        wait_strobe(n);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_strobe", 64'(bus.strobe), 64'd0);
        chk("t6_rst_tvalid", 64'(bus.phase_tvalid), 64'd0);
        chk("t6_rst_busy", 64'(bus.busy), 64'd0);
        chk("t6_rst_done", 64'(bus.done), 64'd0);
        chk("t6_rst_freq", 64'($unsigned(bus.freq_out)), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
